// File: rtl/svc_rv_ex_muldiv_pkg.sv
// Shared M-extension funct3 encodings, also used by decode.
package svc_rv_ex_muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic logic f3_signed_div(logic [2:0] f3);
    return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/svc_rv_divider.sv
// Iterative unsigned restoring divider: latches operands on start, one quotient
// bit per cycle; done flags the last iteration with quotient/remainder valid alongside it.
module svc_rv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   counter;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, dvsr};
  assign fits     = !diff[XLEN];
  assign quo_next = {quo[XLEN-2:0], fits};
  assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];

  // Outputs are the post-step values so the caller can register them on the last edge.
  assign done      = active && (counter == CW'(XLEN - 1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      counter <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
    end else if (abort) begin
      active  <= 1'b0;
      counter <= '0;
    end else if (start) begin
      active  <= 1'b1;
      counter <= '0;
      quo     <= dividend;
      rem     <= '0;
      dvsr    <= divisor;
    end else if (active) begin
      quo <= quo_next;
      rem <= rem_next;
      if (done) begin
        active  <= 1'b0;
        counter <= '0;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: rtl/svc_rv_ex_muldiv.sv
// Multi-cycle RV32M/RV64M execute unit: MUL 3 cycles, DIV XLEN+2 cycles in EX.
// Define SVC_RV_MULDIV_DIV_EARLY_EN to finish x/0 and signed MIN/-1 in 2 cycles.
module svc_rv_ex_muldiv
  import svc_rv_ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_advance,
  input  logic            is_m_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [XLEN-1:0] op_a, op_b;
  logic [2:0]      f3;
  logic            q_neg, r_neg, div_zero, div_ovf, valid_q;

  function automatic logic [XLEN-1:0] special_res(logic [2:0] f, logic [XLEN-1:0] a, logic zero);
    if (zero) return f[1] ? a : '1;
    return f[1] ? '0 : MIN;
  endfunction

  // Operand classification done on the raw inputs while in IDLE.
  logic            in_signed, in_zero, in_ovf, early_special, div_start;
  logic [XLEN-1:0] abs_a, abs_b;

  assign in_signed = f3_signed_div(funct3_ex);
  assign in_zero   = (rs2_data == '0);
  assign in_ovf    = in_signed && (rs1_data == MIN) && (rs2_data == '1);
  assign abs_a     = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
  assign abs_b     = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
`ifdef SVC_RV_MULDIV_DIV_EARLY_EN
  assign early_special = in_zero || in_ovf;
`else
  assign early_special = 1'b0;
`endif
  assign div_start = (state == IDLE) && is_m_ex && !flush && funct3_ex[2] && !early_special;

  logic            div_done;
  logic [XLEN-1:0] div_q, div_r;

  svc_rv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // One extra sign bit per operand lets a single signed multiply cover all three signedness modes.
  logic                   sa, sb;
  logic signed [2*XLEN+1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]        mul_res, q_fix, r_fix, div_res;

  assign sa      = (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU);
  assign sb      = (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH);
  assign a_ext   = {{(XLEN+2){sa & op_a[XLEN-1]}}, op_a};
  assign b_ext   = {{(XLEN+2){sb & op_b[XLEN-1]}}, op_b};
  assign prod    = a_ext * b_ext;
  assign mul_res = (f3 == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign q_fix   = q_neg ? -div_q : div_q;
  assign r_fix   = r_neg ? -div_r : div_r;
  assign div_res = (div_zero || div_ovf) ? special_res(f3, op_a, div_zero)
                                         : (f3[1] ? r_fix : q_fix);

  assign busy         = rst_n && is_m_ex && !flush && (state != DONE);
  assign result_valid = valid_q && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      result   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      f3       <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (is_m_ex) begin
          op_a     <= rs1_data;
          op_b     <= rs2_data;
          f3       <= funct3_ex;
          q_neg    <= in_signed && !in_zero && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
          r_neg    <= in_signed && rs1_data[XLEN-1];
          div_zero <= in_zero;
          div_ovf  <= in_ovf;
          if (!funct3_ex[2]) begin
            state <= MUL;
          end else if (early_special) begin
            result  <= special_res(funct3_ex, rs1_data, in_zero);
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            state <= DIV;
          end
        end
        MUL: begin
          result  <= mul_res;
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DIV: if (div_done) begin
          result  <= div_res;
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DONE: if (ex_advance) begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_rv_ex_muldiv.sv
// Directed bench for svc_rv_ex_muldiv with a RISC-V arithmetic reference model.
module tb_svc_rv_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_advance, is_m_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, result_valid;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  svc_rv_ex_muldiv #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .ex_advance   (ex_advance),
    .is_m_ex      (is_m_ex),
    .funct3_ex    (funct3_ex),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural RISC-V M-extension result, from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      sp, su;
    logic [63:0] up;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    sp  = longint'(sa) * longint'(sb);
    su  = longint'(sa) * longint'({32'd0, b});
    up  = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: return sp[31:0];
      3'd1: return sp[63:32];
      3'd2: return su[63:32];
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles the instruction occupies in EX, including the result cycle.
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (!f[2]) return 3;
`ifdef SVC_RV_MULDIV_DIV_EARLY_EN
    if (special) return 2;
`endif
    if (special) return 34;
    return 34;
  endfunction

  // Issue one op, hold it in DONE for 'hold' extra cycles, check every cycle against the model.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int hold);
    logic [31:0] exp;
    int          lat;
    exp = model(f, a, b);
    lat = model_lat(f, a, b);
    for (int c = 0; c < lat + hold; c++) begin
      @(negedge clk);
      is_m_ex    = 1'b1;
      flush      = 1'b0;
      funct3_ex  = f;
      ex_advance = (c == lat - 1 + hold);
      if (c == 0) begin
        rs1_data = a;
        rs2_data = b;
      end else begin
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      #1;
      check({name, " busy"}, 32'(busy), 32'(c < lat - 1));
      check({name, " result_valid"}, 32'(result_valid), 32'(c >= lat - 1));
      if (c >= lat - 1) check({name, " result"}, result, exp);
      if (c == lat - 1) check({name, " literal"}, result, lit);
    end
    @(negedge clk);
    is_m_ex    = 1'b0;
    ex_advance = 1'b0;
    #1;
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " idle result_valid"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_advance = 1'b0; is_m_ex = 1'b1;
    funct3_ex = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6;
    @(negedge clk); #1;
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result", result, 32'd0);
    is_m_ex = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk); #1;
    check("post-reset busy", 32'(busy), 32'd0);

    run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("MULHU ff*ff",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("MULHSU -1*ff",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
    run_op("DIV -20/3",       3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 0);
    run_op("REM -20/3",       3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 0);
    run_op("DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        0);
    run_op("REMU 100/7",      3'd7, 32'd100,        32'd7,         32'd2,         0);
    run_op("DIV 5/0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("REMU 5/0",        3'd7, 32'd5,          32'd0,         32'd5,         0);
    run_op("REM -7/0",        3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
    run_op("DIV min/-1",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("REM min/-1",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    run_op("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("MUL hold",        3'd0, 32'd6,          32'd9,         32'd54,        4);

    // Flush during DIV iteration 10.
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      is_m_ex = 1'b1; funct3_ex = 3'd4; ex_advance = 1'b0;
      rs1_data = 32'hFFFF_FFEC; rs2_data = 32'd3;
      flush = (c == 11);
      #1;
      check("flush busy", 32'(busy), 32'(c < 11));
      check("flush result_valid", 32'(result_valid), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      flush = 1'b0; is_m_ex = 1'b0;
      #1;
      check("post-flush result_valid", 32'(result_valid), 32'd0);
      check("post-flush busy", 32'(busy), 32'd0);
    end
    // A new op arriving together with flush must not start.
    @(negedge clk);
    is_m_ex = 1'b1; flush = 1'b1; funct3_ex = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2;
    #1;
    check("flush+start busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      is_m_ex = 1'b0; flush = 1'b0;
      #1;
      check("flush+start result_valid", 32'(result_valid), 32'd0);
    end
    run_op("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'd12, 0);

    // Reset in the middle of a DIV with is_m_ex held high.
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      is_m_ex = 1'b1; funct3_ex = 3'd5; ex_advance = 1'b0;
      rs1_data = 32'd100; rs2_data = 32'd7;
      rst_n = (c != 5);
      #1;
      check("mid-reset busy", 32'(busy), 32'(c < 5));
    end
    @(negedge clk); #1;
    check("mid-reset result_valid", 32'(result_valid), 32'd0);
    check("mid-reset result", result, 32'd0);
    check("mid-reset busy held", 32'(busy), 32'd0);
    is_m_ex = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk); #1;
    check("after reset result_valid", 32'(result_valid), 32'd0);
    run_op("REMU after reset", 3'd7, 32'd100, 32'd7, 32'd2, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
